// File: rtl/valid_stream_capture_pkg.sv
// Shared constants and helpers for the valid_stream_capture block.
package valid_stream_capture_pkg;

  localparam int DROP_COUNT_WIDTH = 16;

  // Occupancy spans 0..DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int occupancy_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/capture_fifo_ram.sv
// Simple dual-port DEPTH x WIDTH storage: synchronous write, asynchronous read
// so the head entry is visible in the cycle after it was written.
module capture_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/valid_stream_capture.sv
// Captures a no-backpressure valid/data stream into a FIFO and replays it over
// valid/ready, flagging almost-full and counting any beats it must drop.
module valid_stream_capture
  import valid_stream_capture_pkg::*;
#(
  parameter int WIDTH                 = 32,
  parameter int DEPTH                 = 16,
  parameter int ALMOST_FULL_THRESHOLD = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  input  logic [WIDTH-1:0]                     data_in,
  output logic                                 valid_out,
  output logic [WIDTH-1:0]                     data_out,
  input  logic                                 ready_in,
  output logic [occupancy_width(DEPTH)-1:0]    count_out,
  output logic                                 almost_full_out,
  output logic                                 overflow_out,
  output logic [DROP_COUNT_WIDTH-1:0]          drop_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = occupancy_width(DEPTH);

  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic                        r_almost_full;
  logic                        r_overflow;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic [CW-1:0] w_count_next;

  // Upstream has valid only: every valid_in beat is offered exactly once.
  // Downstream is strict valid/ready: a beat transfers on a cycle where
  // valid_out & ready_in; valid_out never drops and data_out never changes
  // until that transfer happens.
  assign w_full    = (r_count == CW'(DEPTH));
  assign valid_out = (r_count != '0);
  assign w_pop     = valid_out & ready_in;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign w_push_ok = valid_in & (~w_full | w_pop);
  assign w_drop    = valid_in & w_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= CW'(ALMOST_FULL_THRESHOLD));
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  capture_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push_ok & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

  assign count_out       = r_count;
  assign almost_full_out = r_almost_full;
  assign overflow_out    = r_overflow;
  assign drop_count_out  = r_drop_count;

endmodule

// File: doc/valid_stream_capture.md
Name: valid_stream_capture

Overview:
- Receiving end of a no-backpressure valid/data output, such as a Kanagawa method result port or a callback argument port.
- Captures every valid beat into an internal FIFO and re-presents the beats to a downstream consumer over valid/ready.
- The source cannot be stalled, so the block:
  - gives an almost-full warning the producer side can use to throttle;
  - detects, counts and flags any beats it drops.
- This is the synthesizable RTL counterpart to the simulation valid-to-mailbox adapter, used at the edges of generated modules.

Parameters:
- WIDTH, 32: width of data_in and data_out in bits.
- DEPTH, 16: FIFO entries; must be a power of two, DEPTH >= 4.
- ALMOST_FULL_THRESHOLD, 12: almost_full_out asserts when occupancy >= this value; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  upstream beat present; this interface has no backpressure.
- data_in  input  WIDTH  upstream data; sampled only when valid_in=1.
- valid_out  output  1  downstream beat available.
- data_out  output  WIDTH  head-of-FIFO data; stable while valid_out=1 and ready_in=0.
- ready_in  input  1  downstream accepts the beat; a pop occurs when valid_out&ready_in.
- count_out  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
- almost_full_out  output  1  registered; equals (count >= ALMOST_FULL_THRESHOLD).
- overflow_out  output  1  sticky; set by the first dropped beat.
- drop_count_out  output  16  number of dropped beats; saturates at 16'hFFFF.

Behaviour:
- One clock, clk. Synchronous active-high reset rst.
- Reset values:
  - valid_out=0, count_out=0, almost_full_out=0, overflow_out=0, drop_count_out=0.
  - data_out is don't-care.
  - Read and write pointers are 0.
- Reset mid-operation discards all stored beats. A valid_in beat in the reset cycle is ignored and not counted as a drop.
- Push/pop definitions:
  - push = valid_in.
  - pop = valid_out & ready_in.
  - ready_in while valid_out=0 has no effect.
- Latency:
  - A beat pushed at edge N into an empty FIFO gives valid_out=1 with that data after edge N, i.e. visible in cycle N+1. It never appears in the same cycle.
  - First-word-fall-through: data_out always shows the head entry.
- Ordering: strict FIFO order. No beat is duplicated.
- Full boundary (count==DEPTH):
  - push and pop in the same cycle: the push is accepted and count stays DEPTH.
  - push without pop: the beat is dropped. overflow_out is set, drop_count_out increments (saturating), and the stored data and count are unchanged.
- Empty boundary (count==0): valid_out=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count update: +1 on push-accepted only, -1 on pop only, unchanged when both or neither occur.
- almost_full_out and count_out reflect the state after the edge; both are registered with no combinational path from inputs.
- overflow_out and drop_count_out clear only on rst.
- No combinational path from valid_in to valid_out. ready_in is not combinationally required by upstream.

Decomposition:
- Shared package valid_stream_capture_pkg holds:
  - the drop-counter width constant DROP_COUNT_WIDTH=16;
  - a helper function computing the occupancy width from DEPTH.
- One sub-module, capture_fifo_ram:
  - simple dual-port, DEPTH x WIDTH;
  - synchronous write, asynchronous or registered-bypass read, so that first-word-fall-through is met.
- Pointer, count and flag logic lives in the top module.

Test Plan:
- Reset, then push 0..9 on consecutive cycles with ready_in=1 -> data_out sequence is 0..9, first valid_out one cycle after the first push, overflow_out=0.
- ready_in=0, push 16 beats 100..115 -> count_out=16. almost_full_out rises on the edge where count reaches 12. No drops. Then ready_in=1 -> 100..115 emerge in order.
- FIFO full, push 3 more beats with ready_in=0 -> overflow_out=1, drop_count_out=3, count_out=16, and the drained data is still 100..115.
- FIFO full, push 7 and pop in the same cycle -> no drop, count stays 16, and 7 emerges last after draining.
- Continuous push of 32768 beats with ready_in=0 after fill -> drop_count_out saturates at 65535 only if more than 65535 beats are dropped. For 32768 drops the value equals 32768 exactly.
- Assert rst for one cycle with 5 beats stored -> next cycle valid_out=0, count_out=0, flags cleared. A subsequent push of 42 appears alone.
